excp_csr_commit: RTL and testbench
==================================

EXCP_CSR_COMMIT -- requirements
Module: excp_csr_commit

Interface
REQ-001 Parameter TLBR_ECODE, default 6'h3F, meaning: Ecode value that marks a TLB-refill exception.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-low (rst==0 resets on the clock edge).
REQ-004 excp_flush  in  1  exception commit strobe from the memory/writeback stage.
REQ-005 ertn_flush  in  1  ERTN commit strobe.
REQ-006 csr_era  in  32  faulting or ERTN instruction PC.
REQ-007 csr_ecode  in  6  exception code.
REQ-008 csr_esubcode  in  9  exception subcode.
REQ-009 va_error  in  1  bad_va is valid.
REQ-010 bad_va  in  32  faulting virtual address.
REQ-011 excp_tlb  in  1  excp_tlb_vppn is valid.
REQ-012 excp_tlbrefill  in  1  exception is a TLB refill.
REQ-013 excp_tlb_vppn  in  19  faulting VPPN.
REQ-014 wb_csr_we  in  1  software CSR write enable.
REQ-015 wb_csr_addr  in  14  software CSR write address.
REQ-016 wb_csr_data  in  32  software CSR write data.
REQ-017 rd_addr  in  14  CSR read address; rd_data  out  32  combinational read data, 0 for unmapped addresses.
REQ-018 redirect_valid  out  1  one-cycle fetch redirect pulse; redirect_pc  out  32  redirect target.
REQ-019 plv  out  2  current privilege level (CRMD.PLV); ie  out  1  CRMD.IE; da  out  1  CRMD.DA; pg  out  1  CRMD.PG.

Function
REQ-020 Mapped CSRs: CRMD 0x000 {PG[4],DA[3],IE[2],PLV[1:0]}, PRMD 0x001 {PIE[2],PPLV[1:0]}, ESTAT 0x005 {EsubCode[30:22],Ecode[21:16],IS[1:0]}, ERA 0x006, BADV 0x007, EENTRY 0x00C {VA[31:6]}, TLBEHI 0x011 {VPPN[31:13]}, TLBRENTRY 0x088 {PA[31:6]}; all unlisted bits read 0 and ignore writes.
REQ-021 Software write: when wb_csr_we=1 and no event is accepted that cycle, the addressed CSR's writable bits take wb_csr_data on the next edge; ESTAT writable bits are IS[1:0] only.
REQ-022 FSM states IDLE and REDIRECT; excp_flush/ertn_flush are accepted only in IDLE.
REQ-023 Exception accept (IDLE, excp_flush=1): PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE, CRMD.PLV<=0, CRMD.IE<=0, ERA<=csr_era, ESTAT.Ecode<=csr_ecode, ESTAT.EsubCode<=csr_esubcode; BADV<=bad_va only if va_error; TLBEHI.VPPN<=excp_tlb_vppn only if excp_tlb; if excp_tlbrefill additionally CRMD.DA<=1, CRMD.PG<=0.
REQ-024 ERTN accept (IDLE, ertn_flush=1, excp_flush=0): CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE; if ESTAT.Ecode==TLBR_ECODE additionally CRMD.DA<=0, CRMD.PG<=1.
REQ-025 Priority in one cycle: excp_flush > ertn_flush > wb_csr_we; the losing software write is dropped, not deferred.
REQ-026 On accept, FSM moves IDLE->REDIRECT; in REDIRECT redirect_valid=1 for exactly that cycle, then REDIRECT->IDLE unconditionally.
REQ-027 redirect_pc, latched at accept: excp with excp_tlbrefill -> {TLBRENTRY[31:6],6'b0}; other excp -> {EENTRY[31:6],6'b0}; ertn -> ERA value before the accept edge (equal to post-edge ERA since ERTN does not write ERA).
REQ-028 Event strobes arriving in REDIRECT are ignored (pipeline is flushing); wb_csr_we in REDIRECT is honoured.
REQ-029 Latency: accept edge N updates CSRs; redirect_valid high in cycle N+1; rd_data reflects new values from cycle N+1.
REQ-030 redirect_pc holds its last value while redirect_valid=0.

Reset
REQ-031 On rst=0 at a clock edge: CRMD=0x00000008 (DA=1, PG=0, IE=0, PLV=0), all other CSRs 0, FSM=IDLE, redirect_valid=0, redirect_pc=0.
REQ-032 Reset overrides any simultaneous event or write; a pending REDIRECT is cancelled with no pulse.

Verification
REQ-033 Write EENTRY=0x1C000040, CRMD PLV=3 IE=1; pulse excp_flush, ecode=0x0B, era=0x1C000100 -> next cycle redirect_valid=1, redirect_pc=0x1C000040, PLV=0, IE=0, PRMD=0x7, ERA=0x1C000100.
REQ-034 Then pulse ertn_flush -> redirect_pc=0x1C000100, PLV=3, IE=1.
REQ-035 TLBRENTRY=0x00008000; excp_flush with excp_tlbrefill, excp_tlb, ecode=0x3F, vppn=0x12345 -> redirect_pc=0x00008000, DA=1, PG=0, TLBEHI=0x2468A000; ertn -> DA=0, PG=1.
REQ-036 excp_flush, ertn_flush, wb_csr_we(ERA=0xDEAD) in same cycle -> exception taken, ERA=csr_era, write dropped; strobe repeated next cycle -> ignored, single pulse.
REQ-037 excp_flush with va_error=0, bad_va=0xFFFF -> BADV unchanged; rd_addr=0x123 -> rd_data=0.
REQ-038 rst=0 asserted in REDIRECT cycle -> redirect_valid=0 after edge, CRMD=0x8.

Source files
------------

// File: rtl/excp_csr_commit.sv
// Exception / ERTN commit unit with the privileged CSR file it updates.
// Accepted events pulse a one-cycle fetch redirect on the following cycle.
module excp_csr_commit #(
  parameter logic [5:0] TLBR_ECODE = 6'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic [31:0] csr_era,
  input  logic [5:0]  csr_ecode,
  input  logic [8:0]  csr_esubcode,
  input  logic        va_error,
  input  logic [31:0] bad_va,
  input  logic        excp_tlb,
  input  logic        excp_tlbrefill,
  input  logic [18:0] excp_tlb_vppn,
  input  logic        wb_csr_we,
  input  logic [13:0] wb_csr_addr,
  input  logic [31:0] wb_csr_data,
  input  logic [13:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  plv,
  output logic        ie,
  output logic        da,
  output logic        pg
);

  localparam logic [13:0] A_CRMD   = 14'h000;
  localparam logic [13:0] A_PRMD   = 14'h001;
  localparam logic [13:0] A_ESTAT  = 14'h005;
  localparam logic [13:0] A_ERA    = 14'h006;
  localparam logic [13:0] A_BADV   = 14'h007;
  localparam logic [13:0] A_EENTRY = 14'h00C;
  localparam logic [13:0] A_TLBEHI = 14'h011;
  localparam logic [13:0] A_TLBREN = 14'h088;

  typedef enum logic {
    S_IDLE,
    S_REDIR
  } state_e;

  state_e state_q, state_d;

  logic [1:0]  crmd_plv_q, crmd_plv_d;
  logic        crmd_ie_q, crmd_ie_d;
  logic        crmd_da_q, crmd_da_d;
  logic        crmd_pg_q, crmd_pg_d;
  logic [1:0]  prmd_pplv_q, prmd_pplv_d;
  logic        prmd_pie_q, prmd_pie_d;
  logic [8:0]  estat_esub_q, estat_esub_d;
  logic [5:0]  estat_ecode_q, estat_ecode_d;
  logic [1:0]  estat_is_q, estat_is_d;
  logic [31:0] era_q, era_d;
  logic [31:0] badv_q, badv_d;
  logic [25:0] eentry_q, eentry_d;
  logic [18:0] tlbehi_q, tlbehi_d;
  logic [25:0] tlbren_q, tlbren_d;
  logic [31:0] rpc_q, rpc_d;

  logic excp_acc;
  logic ertn_acc;
  logic sw_we;

  always_comb begin
    state_d  = state_q;
    excp_acc = 1'b0;
    ertn_acc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        excp_acc = excp_flush;
        ertn_acc = ertn_flush & ~excp_flush;
        if (excp_acc | ertn_acc) begin
          state_d = S_REDIR;
        end
      end
      S_REDIR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A software write losing to an event is dropped, never replayed
    sw_we = wb_csr_we & ~excp_acc & ~ertn_acc;
  end

  always_comb begin
    crmd_plv_d    = crmd_plv_q;
    crmd_ie_d     = crmd_ie_q;
    crmd_da_d     = crmd_da_q;
    crmd_pg_d     = crmd_pg_q;
    prmd_pplv_d   = prmd_pplv_q;
    prmd_pie_d    = prmd_pie_q;
    estat_esub_d  = estat_esub_q;
    estat_ecode_d = estat_ecode_q;
    estat_is_d    = estat_is_q;
    era_d         = era_q;
    badv_d        = badv_q;
    eentry_d      = eentry_q;
    tlbehi_d      = tlbehi_q;
    tlbren_d      = tlbren_q;
    rpc_d         = rpc_q;

    if (sw_we) begin
      unique case (wb_csr_addr)
        A_CRMD: begin
          crmd_plv_d = wb_csr_data[1:0];
          crmd_ie_d  = wb_csr_data[2];
          crmd_da_d  = wb_csr_data[3];
          crmd_pg_d  = wb_csr_data[4];
        end
        A_PRMD: begin
          prmd_pplv_d = wb_csr_data[1:0];
          prmd_pie_d  = wb_csr_data[2];
        end
        A_ESTAT:  estat_is_d = wb_csr_data[1:0];
        A_ERA:    era_d      = wb_csr_data;
        A_BADV:   badv_d     = wb_csr_data;
        A_EENTRY: eentry_d   = wb_csr_data[31:6];
        A_TLBEHI: tlbehi_d   = wb_csr_data[31:13];
        A_TLBREN: tlbren_d   = wb_csr_data[31:6];
        default: ;
      endcase
    end

    if (excp_acc) begin
      prmd_pplv_d   = crmd_plv_q;
      prmd_pie_d    = crmd_ie_q;
      crmd_plv_d    = 2'd0;
      crmd_ie_d     = 1'b0;
      era_d         = csr_era;
      estat_ecode_d = csr_ecode;
      estat_esub_d  = csr_esubcode;
      if (va_error) begin
        badv_d = bad_va;
      end
      if (excp_tlb) begin
        tlbehi_d = excp_tlb_vppn;
      end
      if (excp_tlbrefill) begin
        crmd_da_d = 1'b1;
        crmd_pg_d = 1'b0;
        rpc_d     = {tlbren_q, 6'b0};
      end else begin
        rpc_d     = {eentry_q, 6'b0};
      end
    end

    if (ertn_acc) begin
      crmd_plv_d = prmd_pplv_q;
      crmd_ie_d  = prmd_pie_q;
      if (estat_ecode_q == TLBR_ECODE) begin
        crmd_da_d = 1'b0;
        crmd_pg_d = 1'b1;
      end
      rpc_d = era_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      crmd_plv_q    <= 2'd0;
      crmd_ie_q     <= 1'b0;
      crmd_da_q     <= 1'b1;
      crmd_pg_q     <= 1'b0;
      prmd_pplv_q   <= 2'd0;
      prmd_pie_q    <= 1'b0;
      estat_esub_q  <= 9'd0;
      estat_ecode_q <= 6'd0;
      estat_is_q    <= 2'd0;
      era_q         <= 32'd0;
      badv_q        <= 32'd0;
      eentry_q      <= 26'd0;
      tlbehi_q      <= 19'd0;
      tlbren_q      <= 26'd0;
      rpc_q         <= 32'd0;
    end else begin
      state_q       <= state_d;
      crmd_plv_q    <= crmd_plv_d;
      crmd_ie_q     <= crmd_ie_d;
      crmd_da_q     <= crmd_da_d;
      crmd_pg_q     <= crmd_pg_d;
      prmd_pplv_q   <= prmd_pplv_d;
      prmd_pie_q    <= prmd_pie_d;
      estat_esub_q  <= estat_esub_d;
      estat_ecode_q <= estat_ecode_d;
      estat_is_q    <= estat_is_d;
      era_q         <= era_d;
      badv_q        <= badv_d;
      eentry_q      <= eentry_d;
      tlbehi_q      <= tlbehi_d;
      tlbren_q      <= tlbren_d;
      rpc_q         <= rpc_d;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    unique case (rd_addr)
      A_CRMD:   rd_data = {27'd0, crmd_pg_q, crmd_da_q,
                           crmd_ie_q, crmd_plv_q};
      A_PRMD:   rd_data = {29'd0, prmd_pie_q, prmd_pplv_q};
      A_ESTAT:  rd_data = {1'b0, estat_esub_q, estat_ecode_q,
                           14'd0, estat_is_q};
      A_ERA:    rd_data = era_q;
      A_BADV:   rd_data = badv_q;
      A_EENTRY: rd_data = {eentry_q, 6'd0};
      A_TLBEHI: rd_data = {tlbehi_q, 13'd0};
      A_TLBREN: rd_data = {tlbren_q, 6'd0};
      default:  rd_data = 32'd0;
    endcase
  end

  assign redirect_valid = (state_q == S_REDIR);
  assign redirect_pc    = rpc_q;
  assign plv            = crmd_plv_q;
  assign ie             = crmd_ie_q;
  assign da             = crmd_da_q;
  assign pg             = crmd_pg_q;

endmodule

// File: tb/tb_excp_csr_commit.sv
// Random + directed bench for excp_csr_commit against a word-level CSR model.
// Model state is one 32-bit word per CSR address, updated by masked writes.
module tb_excp_csr_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        excp_flush, ertn_flush;
  logic [31:0] csr_era;
  logic [5:0]  csr_ecode;
  logic [8:0]  csr_esubcode;
  logic        va_error;
  logic [31:0] bad_va;
  logic        excp_tlb, excp_tlbrefill;
  logic [18:0] excp_tlb_vppn;
  logic        wb_csr_we;
  logic [13:0] wb_csr_addr;
  logic [31:0] wb_csr_data;
  logic [13:0] rd_addr;
  logic [31:0] rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  plv;
  logic        ie, da, pg;

  int checks = 0;
  int errors = 0;

  logic [31:0] m [0:255];
  bit          busy;
  logic [31:0] rpc;

  always #5 clk = ~clk;

  excp_csr_commit #(.TLBR_ECODE(6'h3F)) dut (
    .clk(clk), .rst(rst),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .csr_era(csr_era), .csr_ecode(csr_ecode),
    .csr_esubcode(csr_esubcode), .va_error(va_error),
    .bad_va(bad_va), .excp_tlb(excp_tlb),
    .excp_tlbrefill(excp_tlbrefill),
    .excp_tlb_vppn(excp_tlb_vppn),
    .wb_csr_we(wb_csr_we), .wb_csr_addr(wb_csr_addr),
    .wb_csr_data(wb_csr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .plv(plv), .ie(ie),
    .da(da), .pg(pg)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input logic [13:0] a);
    case (a)
      14'h000: return 32'h0000_001F;
      14'h001: return 32'h0000_0007;
      14'h005: return 32'h0000_0003;
      14'h006: return 32'hFFFF_FFFF;
      14'h007: return 32'hFFFF_FFFF;
      14'h00C: return 32'hFFFF_FFC0;
      14'h011: return 32'hFFFF_E000;
      14'h088: return 32'hFFFF_FFC0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [13:0] a);
    if (a < 14'd256) return m[a[7:0]];
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m[i] = 32'h0;
    m[0] = 32'h8;
    busy = 1'b0;
    rpc  = 32'h0;
  endtask

  task automatic model_step();
    bit ae, ar;
    logic [31:0] wm;
    if (!rst) begin
      model_reset();
      return;
    end
    ae = !busy && excp_flush;
    ar = !busy && !excp_flush && ertn_flush;
    if (ae) begin
      // PPLV/PIE sit at the same bit positions as PLV/IE
      m[1] = m[0] & 32'h7;
      m[0] = m[0] & ~32'h7;
      m[6] = csr_era;
      m[5] = (m[5] & 32'h3) | (32'(csr_esubcode) << 22)
           | (32'(csr_ecode) << 16);
      if (va_error) m[7] = bad_va;
      if (excp_tlb) m[8'h11] = 32'(excp_tlb_vppn) << 13;
      if (excp_tlbrefill) begin
        m[0] = (m[0] | 32'h8) & ~32'h10;
        rpc  = m[8'h88];
      end else begin
        rpc  = m[8'h0C];
      end
    end else if (ar) begin
      m[0] = (m[0] & ~32'h7) | (m[1] & 32'h7);
      if (((m[5] >> 16) & 32'h3F) == 32'h3F)
        m[0] = (m[0] & ~32'h8) | 32'h10;
      rpc = m[6];
    end else if (wb_csr_we) begin
      wm = wmask(wb_csr_addr);
      if (wm != 0)
        m[wb_csr_addr[7:0]] = (m[wb_csr_addr[7:0]] & ~wm)
                            | (wb_csr_data & wm);
    end
    busy = ae || ar;
  endtask

  task automatic cycle();
    logic [31:0] c;
    model_step();
    @(posedge clk);
    #1;
    c = m[0];
    chk("rv", 32'(redirect_valid), 32'(busy));
    chk("rpc", redirect_pc, rpc);
    chk("plv", 32'(plv), 32'(c[1:0]));
    chk("ie", 32'(ie), 32'(c[2]));
    chk("da", 32'(da), 32'(c[3]));
    chk("pg", 32'(pg), 32'(c[4]));
    chk("rd", rd_data, mread(rd_addr));
    @(negedge clk);
  endtask

  task automatic idle_in();
    rst = 1'b1;
    excp_flush = 1'b0; ertn_flush = 1'b0;
    csr_era = '0; csr_ecode = '0; csr_esubcode = '0;
    va_error = 1'b0; bad_va = '0;
    excp_tlb = 1'b0; excp_tlbrefill = 1'b0;
    excp_tlb_vppn = '0;
    wb_csr_we = 1'b0; wb_csr_addr = '0; wb_csr_data = '0;
    rd_addr = '0;
  endtask

  task automatic sw(input logic [13:0] a, input logic [31:0] d);
    idle_in();
    wb_csr_we = 1'b1; wb_csr_addr = a; wb_csr_data = d;
    cycle();
  endtask

  logic [13:0] amap [8];

  initial begin
    amap = '{14'h000, 14'h001, 14'h005, 14'h006,
             14'h007, 14'h00C, 14'h011, 14'h088};
    idle_in();
    rst = 1'b0;
    excp_flush = 1'b1;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_crmd", rd_data, 32'h8);
    chk("rst_rv", 32'(redirect_valid), 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);

    // Exception entry then ERTN
    sw(14'h00C, 32'h1C00_0040);
    sw(14'h000, 32'h0000_0007);
    idle_in();
    excp_flush = 1'b1; csr_ecode = 6'h0B;
    csr_era = 32'h1C00_0100; rd_addr = 14'h001;
    cycle();
    chk("x_rv", 32'(redirect_valid), 32'h1);
    chk("x_rpc", redirect_pc, 32'h1C00_0040);
    chk("x_plv", 32'(plv), 32'h0);
    chk("x_ie", 32'(ie), 32'h0);
    chk("x_prmd", rd_data, 32'h7);
    idle_in(); rd_addr = 14'h006;
    cycle();
    chk("x_era", rd_data, 32'h1C00_0100);
    chk("x_rv0", 32'(redirect_valid), 32'h0);
    idle_in(); ertn_flush = 1'b1;
    cycle();
    chk("r_rpc", redirect_pc, 32'h1C00_0100);
    chk("r_plv", 32'(plv), 32'h3);
    chk("r_ie", 32'(ie), 32'h1);
    idle_in();
    cycle();
    chk("r_hold", redirect_pc, 32'h1C00_0100);

    // TLB refill entry and return
    sw(14'h088, 32'h0000_8000);
    idle_in();
    excp_flush = 1'b1; excp_tlbrefill = 1'b1; excp_tlb = 1'b1;
    csr_ecode = 6'h3F; excp_tlb_vppn = 19'h12345;
    rd_addr = 14'h011;
    cycle();
    chk("t_rpc", redirect_pc, 32'h0000_8000);
    chk("t_da", 32'(da), 32'h1);
    chk("t_pg", 32'(pg), 32'h0);
    chk("t_ehi", rd_data, 32'h2468_A000);
    idle_in();
    cycle();
    idle_in(); ertn_flush = 1'b1;
    cycle();
    chk("tr_da", 32'(da), 32'h0);
    chk("tr_pg", 32'(pg), 32'h1);
    idle_in();
    cycle();

    // Simultaneous strobes: exception wins, write dropped
    idle_in();
    excp_flush = 1'b1; ertn_flush = 1'b1; csr_era = 32'h1C00_0200;
    wb_csr_we = 1'b1; wb_csr_addr = 14'h006; wb_csr_data = 32'hDEAD;
    cycle();
    chk("p_rv", 32'(redirect_valid), 32'h1);
    idle_in();
    excp_flush = 1'b1; ertn_flush = 1'b1; rd_addr = 14'h006;
    csr_era = 32'h5555_0000;
    cycle();
    chk("p_era", rd_data, 32'h1C00_0200);
    chk("p_single", 32'(redirect_valid), 32'h0);

    // BADV untouched without va_error; unmapped read
    sw(14'h007, 32'hA5A5_0000);
    idle_in();
    excp_flush = 1'b1; bad_va = 32'hFFFF; rd_addr = 14'h007;
    cycle();
    chk("b_badv", rd_data, 32'hA5A5_0000);
    idle_in(); rd_addr = 14'h123;
    cycle();
    chk("b_unmap", rd_data, 32'h0);

    // Reset during REDIRECT cancels the pulse
    idle_in(); excp_flush = 1'b1;
    cycle();
    idle_in(); rst = 1'b0;
    cycle();
    chk("rr_rv", 32'(redirect_valid), 32'h0);
    chk("rr_crmd", rd_data, 32'h8);

    for (int n = 0; n < 3000; n++) begin
      idle_in();
      rst = ($urandom_range(99) != 0);
      excp_flush = ($urandom_range(99) < 15);
      ertn_flush = ($urandom_range(99) < 15);
      csr_era = $urandom;
      csr_ecode = ($urandom_range(3) == 0) ? 6'h3F : 6'($urandom);
      csr_esubcode = 9'($urandom);
      va_error = 1'($urandom);
      bad_va = $urandom;
      excp_tlb = 1'($urandom);
      excp_tlbrefill = ($urandom_range(3) == 0);
      excp_tlb_vppn = 19'($urandom);
      wb_csr_we = ($urandom_range(99) < 40);
      wb_csr_addr = ($urandom_range(7) == 0) ? 14'($urandom)
                  : amap[$urandom_range(7)];
      wb_csr_data = $urandom;
      rd_addr = ($urandom_range(7) == 0) ? 14'($urandom)
              : amap[$urandom_range(7)];
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
